// File: rtl/alu_divider_seq.sv
// alu_divider_seq
//   Iterative radix-2 restoring integer divider, one quotient bit per clock.
//   Signed operands are divided as magnitudes and the signs are applied in a
//   final fix-up step (quotient truncates toward zero, remainder follows the
//   dividend). Divide-by-zero and the signed MIN / -1 overflow complete early.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   in_signed             1 = two's-complement operands, 0 = unsigned
//   dividend, divisor     LEN_DATA-bit operands
//   out_valid / out_ready result handshake
//   quotient, remainder   LEN_DATA-bit results, held after the handshake
//   div_zero              divisor was zero (qualified by out_valid)
module alu_divider_seq #(
  parameter int LEN_DATA = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [LEN_DATA-1:0] dividend,
  input  logic [LEN_DATA-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] quotient,
  output logic [LEN_DATA-1:0] remainder,
  output logic                div_zero
);

  localparam int W     = LEN_DATA;
  localparam int CNT_W = $clog2(W);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       dvd_q, dvd_d;         // raw dividend as accepted
  logic [W-1:0]       dvs_q, dvs_d;         // raw divisor, then its magnitude
  logic [W-1:0]       quo_q, quo_d;         // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]       rem_q, rem_d;         // partial remainder (always < divisor, so W bits hold it)
  logic               sgn_op_q, sgn_op_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [W-1:0]       quotient_q, quotient_d;
  logic [W-1:0]       remainder_q, remainder_d;
  logic               div_zero_q, div_zero_d;

  logic               dvd_neg, dvs_neg;
  logic [W:0]         trial;

  // Two's-complement negate when requested; modulo 2^W so MOST_NEG maps to itself.
  function automatic logic [W-1:0] neg_cond(input logic [W-1:0] v, input logic neg);
    return neg ? ((~v) + W'(1)) : v;
  endfunction

  assign dvd_neg = sgn_op_q & dvd_q[W-1];
  assign dvs_neg = sgn_op_q & dvs_q[W-1];

  // Shift the next dividend bit into the remainder and try to subtract the divisor.
  // A clear borrow bit (trial[W]) means the subtraction fits.
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    sgn_op_d    = sgn_op_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d    = dividend;
          dvs_d    = divisor;
          sgn_op_d = in_signed;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        q_neg_d = dvd_neg ^ dvs_neg;
        r_neg_d = dvd_neg;
        quo_d   = neg_cond(dvd_q, dvd_neg);
        dvs_d   = neg_cond(dvs_q, dvs_neg);
        cnt_d   = CNT_W'(W - 1);
        rem_d   = '0;
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
          div_zero_d  = 1'b1;
          state_d     = S_DONE;
        end else if (sgn_op_q && (dvd_q == MOST_NEG) && (dvs_q == '1)) begin
          // MIN / -1 overflows; the wrapped quotient is MIN itself.
          quotient_d  = dvd_q;
          remainder_d = '0;
          div_zero_d  = 1'b0;
          state_d     = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
        end else begin
          rem_d = {rem_q[W-2:0], quo_q[W-1]};
        end
        quo_d = {quo_q[W-2:0], ~trial[W]};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        quotient_d  = neg_cond(quo_q, q_neg_q);
        remainder_d = neg_cond(rem_q, r_neg_q);
        div_zero_d  = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      sgn_op_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      sgn_op_q    <= sgn_op_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Testbench for alu_divider_seq (LEN_DATA = 32): directed vectors with literal
// expectations, plus a per-cycle monitor comparing every valid result against
// an arithmetic reference model and checking result latency.
module tb_alu_divider_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int errors = 0;
  int checks = 0;

  alu_divider_seq #(.LEN_DATA(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division on 64-bit values, truncated to W bits.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      dz = 1'b0;
      lat = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 2 : W + 3;
    end else begin
      ua = {32'b0, a};
      ub = {32'b0, b};
      q = W'(ua / ub);
      r = W'(ua % ub);
      dz = 1'b0;
      lat = W + 3;
    end
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  int           cyc = 0;
  int           acc_cyc = 0;
  int           exp_lat = 0;
  bit           pending = 0;
  bit           first = 0;
  logic [W-1:0] exp_q, exp_r;
  logic         exp_dz;

  always @(negedge clk) begin
    cyc++;
    if (out_valid === 1'b1) begin
      checks++;
      if (!pending) begin
        errors++;
        $display("FAIL mon_stale out_valid=1 with no outstanding operation at cycle %0d", cyc);
      end else begin
        if (quotient !== exp_q || remainder !== exp_r || div_zero !== exp_dz) begin
          errors++;
          $display("FAIL mon_result actual q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                   quotient, remainder, div_zero, exp_q, exp_r, exp_dz);
        end
        if (first) begin
          checks++;
          if (cyc - acc_cyc != exp_lat) begin
            errors++;
            $display("FAIL mon_latency actual=%0d required=%0d", cyc - acc_cyc, exp_lat);
          end
          first = 0;
        end
      end
    end else if (pending && first && (cyc - acc_cyc) > exp_lat) begin
      checks++;
      errors++;
      $display("FAIL mon_late actual>%0d required=%0d", exp_lat, exp_lat);
      first = 0;
    end

    if (rst === 1'b1) begin
      pending = 0;
      first   = 0;
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) pending = 0;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        model(dividend, divisor, in_signed, exp_q, exp_r, exp_dz, exp_lat);
        pending = 1;
        first   = 1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_timeout actual in_ready=%b required=1", in_ready);
    end
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    in_signed = s;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL result_timeout actual out_valid=%b required=1", out_valid);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz);
    start_op(a, b, s);
    wait_valid();
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dz"}, W'(div_zero), W'(edz));
    tick();
    chk({nm, "_ovdrop"}, W'(out_valid), '0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_quotient",  quotient,      '0);
    chk("rst_remainder", remainder,     '0);
    chk("rst_div_zero",  W'(div_zero),  '0);

    run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
    run_op("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run_op("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
    run_op("s-7_-2",   32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0);
    run_op("umax_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0);
    run_op("umax_2",   32'hFFFF_FFFF,  32'd2,          1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0);
    run_op("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1);
    run_op("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1);
    run_op("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
    run_op("u_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);

    // Backpressure: result must hold while out_ready is low; busy ignores in_valid.
    out_ready = 1'b0;
    start_op(32'd1000, 32'd10, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      dividend  = 32'd77;
      divisor   = 32'd3;
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_quotient",  quotient,      32'd100);
      chk("bp_remainder", remainder,     32'd0);
      chk("bp_in_ready",  W'(in_ready),  '0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after", W'(in_ready),  W'(1));
    chk("bp_ov_after",    W'(out_valid), '0);
    chk("bp_held_q",      quotient,      32'd100);
    run_op("u9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0);

    // Reset in the middle of CALC discards the operation.
    start_op(32'd12345, 32'd7, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready",  W'(in_ready),  W'(1));
    chk("mid_rst_out_valid", W'(out_valid), '0);
    chk("mid_rst_quotient",  quotient,      '0);
    chk("mid_rst_remainder", remainder,     '0);
    chk("mid_rst_div_zero",  W'(div_zero),  '0);
    repeat (45) tick();
    chk("mid_rst_no_stale",  W'(out_valid), '0);
    run_op("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
